mux_sel_arbiter: RTL and testbench

//   Round-robin arbiter that shares the 4:1 mux (inputs a/b/c/d, selects s1/s0)

---
 rtl/mux_sel_arbiter.sv | 114 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux among four requesters, with a bounded tenure
// and a one-cycle break-before-make gap. Optional MUX_ARB_LOCK_EN adds a lock input.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] grant,
  output logic       s1,
  output logic       s0,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [1:0]       pick;
  logic             found;
  logic             rival;
  logic             preempt_en;

  // Rotating scan starting just after the last owner.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[2'(last_q + 2'(k))]) begin
        found = 1'b1;
        pick  = 2'(last_q + 2'(k));
      end
    end
  end

  // In GRANT, grant_q is exactly the owner mask, so anything else requesting is a rival.
  assign rival = |(req & ~grant_q);

`ifdef MUX_ARB_LOCK_EN
  assign preempt_en = ~lock;
`else
  assign preempt_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          grant_d = 4'(4'b0001 << pick);
          sel_d   = pick;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // >= so a rival arriving after saturation (or after lock drops) still preempts.
        if (!req[sel_q] || (preempt_en && rival && (cnt_q >= HOLD_LAST))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = sel_q;
        end else if (cnt_q != HOLD_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: a behavioural model pushes the expected
// grant/select/busy for every driven cycle; the result is popped after the edge.
module tb_mux_sel_arbiter;

  localparam int unsigned MAX_HOLD = 8;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       lock_v = 1'b0;
  logic [3:0] grant;
  logic       s1, s0, busy;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  // behavioural model state
  int m_busy, m_owner, m_last, m_cnt;

  logic [3:0] obs_grant;
  logic [1:0] obs_sel;

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
`ifdef MUX_ARB_LOCK_EN
    .lock  (lock_v),
`endif
    .grant (grant),
    .s1    (s1),
    .s0    (s0),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = 3;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic lk);
    int i;
    if (m_busy == 0) begin
      for (int k = 1; k <= 4; k++) begin
        i = (m_last + k) % 4;
        if (m_busy == 0 && r[i]) begin
          m_busy  = 1;
          m_owner = i;
          m_cnt   = 0;
        end
      end
    end else begin
      if (!r[m_owner] ||
          (!lk && m_cnt >= MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000)) begin
        m_busy = 0;
        m_last = m_owner;
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt++;
      end
    end
  endtask

  // Called at a negedge: drive, predict, clock, then compare at the following negedge.
  task automatic step(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r, lock_v);
    e.g = (m_busy != 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
    e.s = 2'(m_owner);
    e.b = (m_busy != 0);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      chk("grant", 8'(grant), 8'(e.g));
      chk("sel", 8'({s1, s0}), 8'(e.s));
      chk("busy", 8'(busy), 8'(e.b));
    end
    obs_grant = grant;
    obs_sel   = {s1, s0};
  endtask

  task automatic do_reset();
    req    = 4'b0000;
    lock_v = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb_q.delete();
  endtask

  int hold;
  logic [3:0] rr;

  initial begin
    model_reset();
    do_reset();
    chk("rst_grant", 8'(grant), 8'h00);
    chk("rst_sel", 8'({s1, s0}), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);

    // idle requests
    for (int c = 0; c < 10; c++) step(4'b0000);
    chk("idle_grant", 8'(grant), 8'h00);

    // all requesting: 8-cycle tenures, one-cycle gaps, rotation 0,1,2,3,0
    do_reset();
    for (int c = 1; c <= 37; c++) begin
      step(4'b1111);
      if (c == 1)  chk("rr_g0", 8'(obs_grant), 8'h01);
      if (c == 8)  chk("rr_g0_end", 8'(obs_grant), 8'h01);
      if (c == 9)  chk("rr_gap0", 8'(obs_grant), 8'h00);
      if (c == 10) chk("rr_g1", 8'(obs_grant), 8'h02);
      if (c == 10) chk("rr_s1", 8'(obs_sel), 8'h01);
      if (c == 18) chk("rr_gap1", 8'(obs_grant), 8'h00);
      if (c == 18) chk("rr_sel_hold", 8'(obs_sel), 8'h01);
      if (c == 19) chk("rr_g2", 8'(obs_grant), 8'h04);
      if (c == 28) chk("rr_g3", 8'(obs_grant), 8'h08);
      if (c == 28) chk("rr_s3", 8'(obs_sel), 8'h03);
      if (c == 37) chk("rr_g0_again", 8'(obs_grant), 8'h01);
    end

    // lone requester keeps the grant indefinitely
    do_reset();
    for (int c = 1; c <= 20; c++) step(4'b0100);
    chk("solo_grant", 8'(obs_grant), 8'h04);
    chk("solo_sel", 8'(obs_sel), 8'h02);
    step(4'b0000);
    chk("solo_release", 8'(obs_grant), 8'h00);

    // async reset mid-tenure clears outputs immediately
    do_reset();
    for (int c = 1; c <= 4; c++) step(4'b0010);
    chk("pre_rst_grant", 8'(obs_grant), 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 8'(grant), 8'h00);
    chk("async_rst_sel", 8'({s1, s0}), 8'h00);
    chk("async_rst_busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb_q.delete();
    step(4'b0011);
    chk("post_rst_first", 8'(obs_grant), 8'h01);

    // owner drops while a rival waits: one gap, then the rival
    do_reset();
    for (int c = 1; c <= 3; c++) step(4'b1100);
    chk("drop_owner", 8'(obs_grant), 8'h04);
    step(4'b1000);
    chk("drop_gap", 8'(obs_grant), 8'h00);
    step(4'b1000);
    chk("drop_next", 8'(obs_grant), 8'h08);
    chk("drop_sel", 8'(obs_sel), 8'h03);

`ifdef MUX_ARB_LOCK_EN
    do_reset();
    lock_v = 1'b1;
    step(4'b0001);
    for (int c = 1; c <= 20; c++) step(4'b0011);
    chk("lock_hold", 8'(obs_grant), 8'h01);
    lock_v = 1'b0;
    step(4'b0011);
    chk("lock_drop_gap", 8'(obs_grant), 8'h00);
    step(4'b0011);
    chk("lock_next", 8'(obs_grant), 8'h02);
`endif

    // random held request patterns against the model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      rr   = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) step(rr);
    end

    chk("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
